// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin arbiter that hands one shared I2C master
// engine to one of NREQ requesters at a time, launches the latched command,
// guards the transaction with a watchdog and returns the result to the winner.
module i2c_cmd_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              ack_err,
  output logic [7:0]        rdata,
  output logic              timeout,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_wdata,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_ack_err,
  input  logic [7:0]        m_rdata
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // The counter never has to hold more than TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT,
    RELEASE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] counter;
  logic             timeout_hit;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand;
  logic [NREQ-1:0]  arb_onehot;

  // Round-robin search: first set req bit starting just after the last winner.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    cand       = '0;
    arb_onehot = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NREQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    arb_onehot[arb_idx] = arb_found;
  end

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      ack_err     <= 1'b0;
      rdata       <= 8'h00;
      timeout     <= 1'b0;
      m_start     <= 1'b0;
      m_addr      <= 7'h00;
      m_rw        <= 1'b0;
      m_wdata     <= 8'h00;
      counter     <= '0;
      timeout_hit <= 1'b0;
      winner      <= '0;
      last_grant  <= IDX_W'(NREQ - 1);
    end else begin
      m_start <= 1'b0;
      case (state)
        IDLE: begin
          gnt     <= '0;
          done    <= '0;
          timeout <= 1'b0;
          ack_err <= 1'b0;
          rdata   <= 8'h00;
          if ((req != '0) && !m_busy) begin
            state <= ARB;
          end
        end
        ARB: begin
          // A request withdrawn before arbitration simply cancels the attempt.
          if (arb_found) begin
            gnt     <= arb_onehot;
            winner  <= arb_idx;
            m_addr  <= req_addr[7*int'(arb_idx) +: 7];
            m_rw    <= req_rw[arb_idx];
            m_wdata <= req_wdata[8*int'(arb_idx) +: 8];
            state   <= LAUNCH;
          end else begin
            state <= IDLE;
          end
        end
        LAUNCH: begin
          m_start     <= 1'b1;
          counter     <= '0;
          timeout_hit <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          counter <= counter + 1'b1;
          // A real completion beats a watchdog expiry in the same cycle.
          if (m_done) begin
            ack_err     <= m_ack_err;
            rdata       <= m_rdata;
            timeout_hit <= 1'b0;
            state       <= RELEASE;
          end else if (counter == CNT_W'(TIMEOUT_CYC - 1)) begin
            ack_err     <= 1'b1;
            rdata       <= 8'h00;
            timeout_hit <= 1'b1;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          done       <= gnt;
          timeout    <= timeout_hit;
          last_grant <= winner;
          gnt        <= '0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: self-checking bench; two instances share all inputs,
// one with the default watchdog and one with a short 16-cycle watchdog.
module tb_i2c_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] req_addr = '0;
  logic [3:0]  req_rw = '0;
  logic [31:0] req_wdata = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ack_err = 1'b0;
  logic [7:0]  m_rdata = '0;

  logic [3:0] gnt_a, done_a, gnt_b, done_b;
  logic       ack_err_a, timeout_a, m_start_a, m_rw_a;
  logic       ack_err_b, timeout_b, m_start_b, m_rw_b;
  logic [7:0] rdata_a, m_wdata_a, rdata_b, m_wdata_b;
  logic [6:0] m_addr_a, m_addr_b;

  bit sel_b = 1'b0;
  logic [3:0] o_gnt, o_done;
  logic       o_ack_err, o_timeout, o_m_start, o_m_rw;
  logic [7:0] o_rdata, o_m_wdata;
  logic [6:0] o_m_addr;

  int checks = 0;
  int errors = 0;
  int model_last = 3;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.NREQ(4), .TIMEOUT_CYC(4096)) dut_a (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt_a), .done(done_a), .ack_err(ack_err_a),
    .rdata(rdata_a), .timeout(timeout_a), .m_start(m_start_a), .m_addr(m_addr_a),
    .m_rw(m_rw_a), .m_wdata(m_wdata_a), .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  i2c_cmd_arbiter #(.NREQ(4), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt_b), .done(done_b), .ack_err(ack_err_b),
    .rdata(rdata_b), .timeout(timeout_b), .m_start(m_start_b), .m_addr(m_addr_b),
    .m_rw(m_rw_b), .m_wdata(m_wdata_b), .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  assign o_gnt     = sel_b ? gnt_b     : gnt_a;
  assign o_done    = sel_b ? done_b    : done_a;
  assign o_ack_err = sel_b ? ack_err_b : ack_err_a;
  assign o_timeout = sel_b ? timeout_b : timeout_a;
  assign o_m_start = sel_b ? m_start_b : m_start_a;
  assign o_m_rw    = sel_b ? m_rw_b    : m_rw_a;
  assign o_rdata   = sel_b ? rdata_b   : rdata_a;
  assign o_m_wdata = sel_b ? m_wdata_b : m_wdata_a;
  assign o_m_addr  = sel_b ? m_addr_b  : m_addr_a;

  typedef struct packed {
    logic       hung;
    logic [3:0] gnt;
    int         n_gnt;
    int         n_start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       start_wide;
    logic       gnt_lost;
    logic       multi_gnt;
    logic [3:0] done;
    int         n_done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       timeout;
  } txn_obs_t;

  // Reference arbitration rule: first requester after the previous winner, with wrap.
  function automatic int exp_winner(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    req    = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    tick();
    tick();
    reset      = 1'b1;
    model_last = 3;
  endtask

  // Drives one transaction as requester set + engine; delay<0 means the engine never completes.
  task automatic do_txn(input logic [3:0] req_v, input int delay, input logic ack_v,
                        input logic [7:0] rd_v, input bit drop, input bit noise,
                        output txn_obs_t o);
    o = '0;
    req = req_v;
    o.hung = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      m_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (o_gnt != '0) begin
        o.n_gnt = k;
        o.hung  = 1'b0;
        break;
      end
    end
    if (o.hung) return;
    o.gnt = o_gnt;
    if (drop) req = '0;
    o.hung = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      m_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (o_m_start) begin
        o.n_start = k;
        o.hung    = 1'b0;
        break;
      end
    end
    if (o.hung) return;
    o.addr  = o_m_addr;
    o.rw    = o_m_rw;
    o.wdata = o_m_wdata;
    o.hung  = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      m_done    = (k == delay);
      m_ack_err = (k == delay) ? ack_v : 1'($urandom_range(0, 1));
      m_rdata   = (k == delay) ? rd_v : 8'($urandom_range(0, 255));
      tick();
      if (k == 1 && o_m_start) o.start_wide = 1'b1;
      if ($countones(o_gnt) > 1) o.multi_gnt = 1'b1;
      if (o_done != '0) begin
        o.done    = o_done;
        o.ack_err = o_ack_err;
        o.rdata   = o_rdata;
        o.timeout = o_timeout;
        o.n_done  = k;
        o.hung    = 1'b0;
        break;
      end
      if (o_gnt != o.gnt) o.gnt_lost = 1'b1;
    end
    m_done = 1'b0;
  endtask

  // Reset forces every output to zero even while requests are pending.
  task automatic test_reset();
    reset     = 1'b0;
    req       = 4'b1111;
    req_addr  = 28'($urandom);
    req_wdata = $urandom;
    m_done    = 1'b1;
    m_rdata   = 8'hFF;
    tick();
    tick();
    tick();
    checks++;
    if (gnt_a !== 4'b0000 || done_a !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_gnt_done: got gnt=%b done=%b expected 0000/0000", gnt_a, done_a);
    end
    checks++;
    if (m_start_a !== 1'b0 || timeout_a !== 1'b0 || ack_err_a !== 1'b0 || rdata_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got start=%b to=%b ack=%b rdata=%h expected 0/0/0/00",
               m_start_a, timeout_a, ack_err_a, rdata_a);
    end
    checks++;
    if (m_addr_a !== 7'h00 || m_rw_a !== 1'b0 || m_wdata_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_cmd: got addr=%h rw=%b wdata=%h expected 00/0/00",
               m_addr_a, m_rw_a, m_wdata_a);
    end
    m_done = 1'b0;
    do_reset();
  endtask

  // Single write to 0x50 completing after 20 cycles.
  task automatic test_single_write();
    txn_obs_t o;
    do_reset();
    req_addr  = 28'($urandom);
    req_wdata = $urandom;
    req_rw    = 4'($urandom);
    req_addr[6:0]  = 7'h50;
    req_wdata[7:0] = 8'hA5;
    req_rw[0]      = 1'b0;
    do_txn(4'b0001, 20, 1'b0, 8'h77, 1'b0, 1'b0, o);
    checks++;
    if (o.hung !== 1'b0 || o.gnt !== 4'b0001 || o.n_gnt != 2 || o.n_start != 1) begin
      errors++;
      $display("[TB] FAIL write_grant: got hung=%b gnt=%b n_gnt=%0d n_start=%0d expected 0/0001/2/1",
               o.hung, o.gnt, o.n_gnt, o.n_start);
    end
    checks++;
    if (o.addr !== 7'h50 || o.wdata !== 8'hA5 || o.rw !== 1'b0 || o.start_wide !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_cmd: got addr=%h wdata=%h rw=%b wide=%b expected 50/a5/0/0",
               o.addr, o.wdata, o.rw, o.start_wide);
    end
    checks++;
    if (o.done !== 4'b0001 || o.n_done != 21 || o.ack_err !== 1'b0 || o.timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_done: got done=%b n_done=%0d ack=%b to=%b expected 0001/21/0/0",
               o.done, o.n_done, o.ack_err, o.timeout);
    end
    tick();
    checks++;
    if (done_a !== 4'b0000 || gnt_a !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL write_done_pulse: got done=%b gnt=%b expected 0000/0000", done_a, gnt_a);
    end
  endtask

  // All requesters held: grants must rotate 0,1,2,3,0.
  task automatic test_round_robin();
    txn_obs_t o;
    int w;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      do_txn(4'b1111, 5, 1'b0, 8'h00, 1'b0, 1'b0, o);
      w = exp_winner(4'b1111, model_last);
      checks++;
      if (o.hung !== 1'b0 || o.gnt !== 4'(1 << w) || o.multi_gnt !== 1'b0 || o.done !== 4'(1 << w)) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: got hung=%b gnt=%b multi=%b done=%b expected gnt=done=%b",
                 t, o.hung, o.gnt, o.multi_gnt, o.done, 4'(1 << w));
      end
      model_last = w;
    end
    checks++;
    if (model_last != 0) begin
      errors++;
      $display("[TB] FAIL rr_order_end: got %0d expected 0", model_last);
    end
  endtask

  // Read from requester 2 answered with a NACK.
  task automatic test_read_nack();
    txn_obs_t o;
    do_reset();
    req_rw = 4'b0100;
    do_txn(4'b0100, 7, 1'b1, 8'h3C, 1'b0, 1'b0, o);
    checks++;
    if (o.hung !== 1'b0 || o.done !== 4'b0100 || o.ack_err !== 1'b1 || o.rdata !== 8'h3C || o.rw !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_nack: got hung=%b done=%b ack=%b rdata=%h rw=%b expected 0/0100/1/3c/1",
               o.hung, o.done, o.ack_err, o.rdata, o.rw);
    end
  endtask

  // Request withdrawn before arbitration: no grant, no launch, priority unchanged.
  task automatic test_req_drop();
    txn_obs_t o;
    bit seen;
    do_reset();
    req = 4'b1010;
    tick();
    req  = 4'b0000;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (gnt_a != '0 || m_start_a || done_a != '0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_before_arb: got activity=%b expected 0", seen);
    end
    do_txn(4'b1010, 3, 1'b0, 8'h00, 1'b1, 1'b0, o);
    checks++;
    if (o.hung !== 1'b0 || o.gnt !== 4'b0010 || o.done !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL drop_after_arb: got hung=%b gnt=%b done=%b expected 0/0010/0010",
               o.hung, o.gnt, o.done);
    end
  endtask

  // Watchdog of 16 cycles with a silent engine.
  task automatic test_timeout();
    txn_obs_t o;
    do_reset();
    sel_b = 1'b1;
    do_txn(4'b0001, -1, 1'b0, 8'h00, 1'b0, 1'b0, o);
    checks++;
    if (o.hung !== 1'b0 || o.done !== 4'b0001 || o.timeout !== 1'b1 || o.n_done != 17) begin
      errors++;
      $display("[TB] FAIL timeout_done: got hung=%b done=%b to=%b n_done=%0d expected 0/0001/1/17",
               o.hung, o.done, o.timeout, o.n_done);
    end
    checks++;
    if (o.ack_err !== 1'b1 || o.rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL timeout_status: got ack=%b rdata=%h expected 1/00", o.ack_err, o.rdata);
    end
    tick();
    checks++;
    if (done_b !== 4'b0000 || timeout_b !== 1'b0 || gnt_b !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL timeout_idle: got done=%b to=%b gnt=%b expected 0000/0/0000",
               done_b, timeout_b, gnt_b);
    end
    sel_b = 1'b0;
  endtask

  // Engine completion lands on the very cycle the watchdog would expire.
  task automatic test_done_vs_expiry();
    txn_obs_t o;
    logic [7:0] rd;
    do_reset();
    sel_b = 1'b1;
    rd = 8'($urandom_range(1, 255));
    do_txn(4'b1000, 16, 1'b0, rd, 1'b0, 1'b0, o);
    checks++;
    if (o.hung !== 1'b0 || o.done !== 4'b1000 || o.n_done != 17 || o.timeout !== 1'b0 ||
        o.ack_err !== 1'b0 || o.rdata !== rd) begin
      errors++;
      $display("[TB] FAIL done_vs_expiry: got done=%b n=%0d to=%b ack=%b rdata=%h expected 1000/17/0/0/%h",
               o.done, o.n_done, o.timeout, o.ack_err, o.rdata, rd);
    end
    sel_b = 1'b0;
  endtask

  // Busy engine holds off arbitration; reset in WAIT abandons the transaction.
  task automatic test_busy_reset();
    bit seen;
    int n;
    do_reset();
    m_busy = 1'b1;
    req    = 4'b0010;
    seen   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (gnt_a != '0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_holdoff: got grant_seen=%b expected 0", seen);
    end
    m_busy = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (gnt_a != '0) begin
        n = k;
        break;
      end
    end
    checks++;
    if (gnt_a !== 4'b0010 || n != 2) begin
      errors++;
      $display("[TB] FAIL busy_release: got gnt=%b after %0d expected 0010 after 2", gnt_a, n);
    end
    m_busy = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    req   = 4'b0000;
    reset = 1'b0;
    tick();
    checks++;
    if (gnt_a !== '0 || done_a !== '0 || m_start_a !== 1'b0 || timeout_a !== 1'b0 ||
        ack_err_a !== 1'b0 || rdata_a !== 8'h00 || m_addr_a !== 7'h00 || m_wdata_a !== 8'h00 || m_rw_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_txn: got gnt=%b done=%b start=%b to=%b ack=%b rdata=%h addr=%h wdata=%h rw=%b expected all zero",
               gnt_a, done_a, m_start_a, timeout_a, ack_err_a, rdata_a, m_addr_a, m_wdata_a, m_rw_a);
    end
    reset  = 1'b1;
    m_busy = 1'b0;
    m_done = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      m_done = 1'b0;
      if (done_a != '0 || gnt_a != '0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got activity=%b expected 0", seen);
    end
  endtask

  // Randomised traffic against the reference arbitration and latency rules.
  task automatic test_random();
    txn_obs_t o;
    logic [3:0] r;
    logic [7:0] rd;
    logic ack;
    int d, w;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      r         = 4'($urandom_range(1, 15));
      req_addr  = 28'($urandom);
      req_rw    = 4'($urandom);
      req_wdata = $urandom;
      d   = $urandom_range(1, 12);
      ack = 1'($urandom_range(0, 1));
      rd  = 8'($urandom_range(0, 255));
      do_txn(r, d, ack, rd, 1'($urandom_range(0, 1)), 1'b1, o);
      w = exp_winner(r, model_last);
      checks++;
      if (o.hung !== 1'b0 || o.gnt !== 4'(1 << w) || o.n_gnt != 2 || o.n_start != 1 ||
          o.start_wide !== 1'b0 || o.gnt_lost !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_grant_%0d: got hung=%b gnt=%b n_gnt=%0d n_start=%0d wide=%b lost=%b expected gnt=%b 2/1",
                 t, o.hung, o.gnt, o.n_gnt, o.n_start, o.start_wide, o.gnt_lost, 4'(1 << w));
      end
      checks++;
      if (o.addr !== req_addr[w*7 +: 7] || o.rw !== req_rw[w] || o.wdata !== req_wdata[w*8 +: 8]) begin
        errors++;
        $display("[TB] FAIL rand_cmd_%0d: got addr=%h rw=%b wdata=%h expected %h/%b/%h",
                 t, o.addr, o.rw, o.wdata, req_addr[w*7 +: 7], req_rw[w], req_wdata[w*8 +: 8]);
      end
      checks++;
      if (o.done !== 4'(1 << w) || o.n_done != d + 1 || o.ack_err !== ack || o.rdata !== rd || o.timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_done_%0d: got done=%b n=%0d ack=%b rdata=%h to=%b expected %b/%0d/%b/%h/0",
                 t, o.done, o.n_done, o.ack_err, o.rdata, o.timeout, 4'(1 << w), d + 1, ack, rd);
      end
      model_last = w;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_nack();
    test_req_drop();
    test_timeout();
    test_done_vs_expiry();
    test_busy_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requester ports.
REQ-002 Parameter TIMEOUT_CYC, default 4096, maximum clk cycles allowed in WAIT before abort.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  NREQ  level request; bit i belongs to requester i.
REQ-006 req_addr  input  7*NREQ  7-bit slave address; requester i at [7i+6:7i].
REQ-007 req_rw  input  NREQ  1=read, 0=write, per requester.
REQ-008 req_wdata  input  8*NREQ  write byte; requester i at [8i+7:8i].
REQ-009 gnt  output  NREQ  one-hot grant; all-zero when no requester owns the master.
REQ-010 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 ack_err  output  1  NACK or timeout flag; valid only while any done bit is high.
REQ-012 rdata  output  8  read byte; valid only while any done bit is high.
REQ-013 timeout  output  1  one-cycle pulse when the watchdog aborts a transaction.
REQ-014 m_start  output  1  one-cycle launch pulse to the I2C master engine.
REQ-015 m_addr  output  7, m_rw output 1, m_wdata output 8: latched command; stable from ARB through RELEASE.
REQ-016 m_busy  input  1  engine busy; m_done input 1 completion pulse; m_ack_err input 1; m_rdata input 8.

Function
REQ-017 FSM states SHALL be IDLE, ARB, LAUNCH, WAIT, RELEASE; all outputs registered.
REQ-018 IDLE: req != 0 and m_busy == 0 -> ARB; otherwise stay in IDLE.
REQ-019 ARB: the winner is the first set req bit searching from (last_grant+1) mod NREQ upward with wrap; the winner's addr/rw/wdata SHALL be latched into m_addr/m_rw/m_wdata; gnt SHALL go one-hot; next state LAUNCH.
REQ-020 Winner with req dropped between IDLE and ARB: the search SHALL use req sampled in ARB; if req == 0 in ARB, return to IDLE with gnt = 0 and no launch.
REQ-021 LAUNCH: m_start = 1 for exactly this cycle; the watchdog counter SHALL clear to 0; next state WAIT.
REQ-022 WAIT: the counter SHALL increment each cycle; m_done = 1 -> RELEASE, capturing m_ack_err and m_rdata.
REQ-023 WAIT: counter == TIMEOUT_CYC-1 without m_done -> RELEASE, with ack_err captured as 1, rdata as 0x00, and timeout pulsed with done.
REQ-024 m_done and watchdog expiry in the same cycle: m_done SHALL win and no timeout pulse SHALL occur.
REQ-025 RELEASE: done[winner] = 1 for one cycle; gnt stays asserted through RELEASE; last_grant <= winner; next state IDLE, with gnt = 0 in IDLE.
REQ-026 A requester dropping req after ARB SHALL NOT abort the transaction; done is still pulsed.
REQ-027 m_done outside WAIT SHALL be ignored; m_busy is checked only in IDLE.
REQ-028 Latency: req high in IDLE at edge N (m_busy = 0) gives gnt at N+1 and m_start at N+2; m_done at edge M gives done at M+1.
REQ-029 Fairness: with all req held high, grants SHALL rotate 0,1,2,3,0,...; a requester waits at most NREQ-1 transactions.

Reset
REQ-030 reset == 0 at a clock edge SHALL force IDLE, with gnt = 0, done = 0, ack_err = 0, rdata = 0x00, timeout = 0, m_start = 0, m_addr = 0, m_rw = 0, m_wdata = 0x00, counter = 0, and last_grant = NREQ-1 so requester 0 has first priority.
REQ-031 Reset asserted mid-transaction SHALL abandon it without a done pulse; the engine is not notified.

Verification
REQ-032 Single write: req = 0001, addr0 = 0x50, rw0 = 0, wdata0 = 0xA5; m_done after 20 cycles with m_ack_err = 0 -> gnt = 0001, m_start pulse with m_addr = 0x50, m_wdata = 0xA5; done = 0001, ack_err = 0.
REQ-033 Round-robin: req = 1111 held, each m_done returned 5 cycles after m_start -> grant order 0,1,2,3,0; never two gnt bits set at once.
REQ-034 Read with NACK: req = 0100, rw2 = 1; m_done with m_ack_err = 1, m_rdata = 0x3C -> done = 0100, ack_err = 1, rdata = 0x3C.
REQ-035 Timeout: TIMEOUT_CYC = 16, m_done never asserted -> done and timeout both high 17 cycles after m_start, ack_err = 1, then IDLE.
REQ-036 Busy hold-off, then reset: m_busy = 1 with req = 0010 gives no gnt; releasing m_busy gives grant; pulsing reset low in WAIT -> all outputs zero next cycle, no done pulse.
REQ-037 Boundary: m_done and watchdog expiry in the same cycle -> done pulses with ack_err = m_ack_err and timeout = 0.
